fpu_64_reciprocal_iter: RTL and testbench

//  Sequential IEEE-754 binary64 reciprocal, 1/in, by Newton-Raphson x' = x*(2 - d*x) from a LUT seed.

---
 rtl/fpu_64_pkg.sv | 28 ++
 rtl/fpu_recip_seed_lut.sv | 17 +
 rtl/fpu_64_reciprocal_iter.sv | 200 ++++++++++++++++++++
 tb/tb_fpu_64_reciprocal_iter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fpu_64_pkg.sv
// Shared binary64 constants, reciprocal FSM state encoding and the seed-table generator.
package fpu_64_pkg;

    localparam int EXP_W    = 11;
    localparam int MANT_W   = 52;
    localparam int EXP_BIAS = 1023;

    localparam logic [63:0] QNAN_64 = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] INF_64  = 64'h7FF0_0000_0000_0000;

    typedef logic [2:0] recip_state_t;

    localparam recip_state_t ST_IDLE  = 3'd0;
    localparam recip_state_t ST_SEED  = 3'd1;
    localparam recip_state_t ST_MUL_T = 3'd2;
    localparam recip_state_t ST_MUL_X = 3'd3;
    localparam recip_state_t ST_NORM  = 3'd4;
    localparam recip_state_t ST_CORR  = 3'd5;
    localparam recip_state_t ST_DONE  = 3'd6;

    // round(512 / (1 + (idx + 0.5)/256)) == round(262144 / (513 + 2*idx)), in integers
    function automatic logic [8:0] recip_seed_calc(input int idx);
        int den;
        den = 513 + 2 * idx;
        return 9'((524288 + den) / (2 * den));
    endfunction

endpackage

// File: rtl/fpu_recip_seed_lut.sv
// 256-entry reciprocal seed ROM: top 8 mantissa bits -> 9-bit seed, seed/512 ~ 1/(1.m).
module fpu_recip_seed_lut
    import fpu_64_pkg::*;
(
    input  logic [7:0] index,
    output logic [8:0] seed
);

    logic [8:0] rom [0:255];

    for (genvar i = 0; i < 256; i++) begin : g_rom
        assign rom[i] = recip_seed_calc(i);
    end

    assign seed = rom[index];

endmodule

// File: rtl/fpu_64_reciprocal_iter.sv
// Sequential binary64 reciprocal by Newton-Raphson on one shared multiplier.
// Define FPU_RECIP_ROUND_EN to add a CORR cycle that makes the result round-to-nearest-even.
module fpu_64_reciprocal_iter
    import fpu_64_pkg::*;
#(
    parameter int ITER   = 3,
    parameter int FRAC_W = 62
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        div_by_zero,
    output logic        underflow,
    output logic        invalid
);

    localparam int DW    = FRAC_W + 2;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int ULP_B = FRAC_W - MANT_W - 1;
    localparam logic [DW-1:0] TWO = {2'b10, {FRAC_W{1'b0}}};
`ifdef FPU_RECIP_ROUND_EN
    localparam logic [DW-1:0]     LOW_MASK = (DW'(1) << ULP_B) - DW'(1);
    localparam logic [DW-1:0]     HALF_ULP = DW'(1) << (ULP_B - 1);
    localparam logic [2*DW-1:0]   ONE_P    = (2*DW)'(1) << (2 * FRAC_W);
`endif

    recip_state_t       state;
    logic [DW-1:0]      d_reg, x_reg, t_reg;
    logic [CNT_W-1:0]   iter_cnt;
    logic               sign_reg, uf_pend;
    logic [EXP_W-1:0]   exp_res;

    logic               in_sign, exp_max, exp_zero, mant_zero, spec_hit;
    logic [EXP_W-1:0]   in_exp;
    logic [MANT_W-1:0]  in_mant;
    logic [63:0]        spec_data;
    logic               spec_dbz, spec_uf, spec_inv;

    logic [DW-1:0]      mul_a, mul_b, prod_q;
    logic [2*DW-1:0]    prod;
    logic [8:0]         seed;
    logic [MANT_W-1:0]  mant_out, res_mant;
    logic [63:0]        result_word;
    logic               unused_prod;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    assign in_sign   = in_data[63];
    assign in_exp    = in_data[62:52];
    assign in_mant   = in_data[51:0];
    assign exp_max   = (in_exp == 11'h7FF);
    assign exp_zero  = (in_exp == 11'h000);
    assign mant_zero = (in_mant == '0);
    assign spec_hit  = exp_max | exp_zero | mant_zero;

    // Operands that need no iteration: NaN, zero/denormal, infinity and exact powers of two
    always_comb begin
        spec_data = '0;
        spec_dbz  = 1'b0;
        spec_uf   = 1'b0;
        spec_inv  = 1'b0;
        if (exp_max && !mant_zero) begin
            spec_data = QNAN_64;
            spec_inv  = ~in_mant[51];
        end else if (exp_zero) begin
            spec_data = {in_sign, INF_64[62:0]};
            spec_dbz  = 1'b1;
        end else if (exp_max) begin
            spec_data = {in_sign, 63'b0};
        end else if (in_exp == 11'd2046) begin
            spec_data = {in_sign, 63'b0};
            spec_uf   = 1'b1;
        end else begin
            spec_data = {in_sign, 11'd2046 - in_exp, {MANT_W{1'b0}}};
        end
    end

    fpu_recip_seed_lut u_seed (
        .index (d_reg[FRAC_W-1 -: 8]),
        .seed  (seed)
    );

    always_comb begin
        mul_a = d_reg;
        mul_b = x_reg;
        case (state)
            ST_MUL_X: begin
                mul_a = x_reg;
                mul_b = TWO - t_reg;
            end
`ifdef FPU_RECIP_ROUND_EN
            ST_CORR:  mul_b = x_reg + HALF_ULP;
`endif
            default: ;
        endcase
    end

    assign prod        = {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, mul_b};
    assign prod_q      = prod[FRAC_W +: DW];
    assign unused_prod = ^{prod[FRAC_W-1:0], prod[2*DW-1:FRAC_W+DW]};

    // x sits in (0.5,1): bit FRAC_W-1 is the hidden one of 2x
    assign mant_out = x_reg[FRAC_W-2 -: MANT_W];

    always_comb begin
        res_mant = mant_out;
`ifdef FPU_RECIP_ROUND_EN
        if (prod < ONE_P) res_mant = mant_out + MANT_W'(1);
`endif
        result_word = uf_pend ? {sign_reg, 63'b0} : {sign_reg, exp_res, res_mant};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            d_reg       <= '0;
            x_reg       <= '0;
            t_reg       <= '0;
            iter_cnt    <= '0;
            sign_reg    <= 1'b0;
            uf_pend     <= 1'b0;
            exp_res     <= '0;
            out_data    <= '0;
            div_by_zero <= 1'b0;
            underflow   <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (spec_hit) begin
                            out_data    <= spec_data;
                            div_by_zero <= spec_dbz;
                            underflow   <= spec_uf;
                            invalid     <= spec_inv;
                            state       <= ST_DONE;
                        end else begin
                            d_reg    <= {2'b01, in_mant, {(FRAC_W-MANT_W){1'b0}}};
                            sign_reg <= in_sign;
                            exp_res  <= 11'd2045 - in_exp;
                            uf_pend  <= (in_exp >= 11'd2045);
                            iter_cnt <= '0;
                            state    <= ST_SEED;
                        end
                    end
                end
                ST_SEED: begin
                    x_reg <= {{(DW-9){1'b0}}, seed} << (FRAC_W - 9);
                    state <= ST_MUL_T;
                end
                ST_MUL_T: begin
                    t_reg <= prod_q;
                    state <= ST_MUL_X;
                end
                ST_MUL_X: begin
                    x_reg <= prod_q;
                    if (iter_cnt == CNT_W'(ITER - 1)) begin
                        state <= ST_NORM;
                    end else begin
                        iter_cnt <= iter_cnt + CNT_W'(1);
                        state    <= ST_MUL_T;
                    end
                end
`ifdef FPU_RECIP_ROUND_EN
                ST_NORM: begin
                    x_reg <= x_reg & ~LOW_MASK;
                    state <= ST_CORR;
                end
                ST_CORR: begin
                    out_data  <= result_word;
                    underflow <= uf_pend;
                    state     <= ST_DONE;
                end
`else
                ST_NORM: begin
                    out_data  <= result_word;
                    underflow <= uf_pend;
                    state     <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        div_by_zero <= 1'b0;
                        underflow   <= 1'b0;
                        invalid     <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_64_reciprocal_iter.sv
// Directed self-checking bench for fpu_64_reciprocal_iter; honours FPU_RECIP_ROUND_EN.
module tb_fpu_64_reciprocal_iter;

`ifdef FPU_RECIP_ROUND_EN
    localparam int        ITER_LAT = 10;
    localparam logic [63:0] TEN_RECIP = 64'h3FB9_9999_9999_999A;
`else
    localparam int        ITER_LAT = 9;
    localparam logic [63:0] TEN_RECIP = 64'h3FB9_9999_9999_9999;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        div_by_zero;
    logic        underflow;
    logic        invalid;

    int num_compared   = 0;
    int num_mismatched = 0;

    always #5 clk = ~clk;

    fpu_64_reciprocal_iter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .div_by_zero (div_by_zero),
        .underflow   (underflow),
        .invalid     (invalid)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        num_compared++;
        if (obs !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present an operand and return #1 after the edge that accepted it
    task automatic applyStimulus(input logic [63:0] d);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic waitResult(output int lat);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!out_valid) checkOutput("result_timeout", 64'(out_valid), 64'd1);
        lat = cyc + 1;
    endtask

    task automatic runOp(input string tag, input logic [63:0] d, input logic [63:0] exp_data,
                         input logic [2:0] exp_flags, input int exp_lat);
        int lat;
        applyStimulus(d);
        waitResult(lat);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_data"}, out_data, exp_data);
        checkOutput({tag, "_flags"}, {61'b0, div_by_zero, underflow, invalid}, {61'b0, exp_flags});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_release"}, {61'b0, out_valid, in_ready, underflow | div_by_zero | invalid},
                    64'b010);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        checkOutput("reset_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_data", out_data, 64'd0);
        checkOutput("reset_flags", {61'b0, div_by_zero, underflow, invalid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("two",       64'h4000_0000_0000_0000, 64'h3FE0_0000_0000_0000, 3'b000, 1);
        runOp("ten",       64'h4024_0000_0000_0000, TEN_RECIP,               3'b000, ITER_LAT);
        runOp("pzero",     64'h0000_0000_0000_0000, 64'h7FF0_0000_0000_0000, 3'b100, 1);
        runOp("ndenorm",   64'h8000_0000_0000_0001, 64'hFFF0_0000_0000_0000, 3'b100, 1);
        runOp("ninf",      64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b000, 1);
        runOp("snan",      64'h7FF0_0000_0000_0001, 64'h7FF8_0000_0000_0000, 3'b001, 1);
        runOp("qnan",      64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 3'b000, 1);
        runOp("big_uf",    64'h7FE0_0000_0000_0001, 64'h0000_0000_0000_0000, 3'b010, ITER_LAT);
        runOp("pow2_uf",   64'h7FE0_0000_0000_0000, 64'h0000_0000_0000_0000, 3'b010, 1);
        runOp("min_norm",  64'h0010_0000_0000_0000, 64'h7FD0_0000_0000_0000, 3'b000, 1);
        runOp("seven",     64'h401C_0000_0000_0000, 64'h3FC2_4924_9249_2492, 3'b000, ITER_LAT);
        runOp("neg_1p5",   64'hBFF8_0000_0000_0000, 64'hBFE5_5555_5555_5555, 3'b000, ITER_LAT);

        // Backpressure: hold the 2.0 result while a 4.0 waits on the input
        begin
            int lat;
            applyStimulus(64'h4000_0000_0000_0000);
            waitResult(lat);
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 64'h4010_0000_0000_0000;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                checkOutput("bp_data", out_data, 64'h3FE0_0000_0000_0000);
                checkOutput("bp_ctrl", {61'b0, out_valid, in_ready, div_by_zero | underflow | invalid},
                            64'b100);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checkOutput("bp_release", {62'b0, out_valid, in_ready}, 64'b01);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checkOutput("bp_next_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_next_data", out_data, 64'h3FD0_0000_0000_0000);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end

        // Reset in the middle of the second MUL_X, then a fresh operand
        applyStimulus(64'h4008_0000_0000_0000);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ctrl", {62'b0, out_valid, in_ready}, 64'b01);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("three", 64'h4008_0000_0000_0000, 64'h3FD5_5555_5555_5555, 3'b000, ITER_LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
